// File: rtl/ifetch_ctrl.sv
// IJVM instruction-byte prefetcher: fills a small byte FIFO from method-area
// memory over a single-outstanding req/ack handshake and serves MBR/MBR2.
module ifetch_ctrl #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pc_load,
    input  logic [ADDR_W-1:0]          pc_in,
    output logic                       mem_rd,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic                       mem_ack,
    input  logic [7:0]                 mem_data,
    input  logic                       consume1,
    input  logic                       consume2,
    output logic                       mbr_valid,
    output logic [7:0]                 mbr_data,
    output logic                       mbr2_valid,
    output logic [15:0]                mbr2_data,
    output logic [ADDR_W-1:0]          pc_out,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] TWO  = CW'(2);

    typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]       count_q, count_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic                mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          fifo_q [DEPTH];

    logic                push;
    logic [CW-1:0]       pop_n;
    logic [CW-1:0]       count_after;
    logic [PTR_W-1:0]    rd_ptr_p1;

    // pc_load outranks any consume; a byte arriving with pc_load is stale
    always_comb begin
        push  = (state_q == FETCH) && mem_ack && !pc_load;
        pop_n = '0;
        if (!pc_load) begin
            if (consume2 && count_q >= TWO)
                pop_n = TWO;
            else if (consume1 && count_q >= ONE)
                pop_n = ONE;
        end
        count_after = count_q + {{(CW-1){1'b0}}, push} - pop_n;
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_after;
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop_n);
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        mem_rd_d   = mem_rd_q;
        mem_addr_d = mem_addr_q;

        if (pc_load) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = pc_in;
        end

        unique case (state_q)
            IDLE: begin
                if (pc_load) begin
                    state_d    = FETCH;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = pc_in;
                end else if (count_q < FULL) begin
                    state_d    = FETCH;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = fetch_pc_q;
                end
            end
            FETCH: begin
                if (pc_load && mem_ack) begin
                    mem_addr_d = pc_in;
                end else if (pc_load) begin
                    // request stays on the bus; its reply is dropped in DISCARD
                    state_d = DISCARD;
                end else if (mem_ack) begin
                    fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                    if (count_after < FULL) begin
                        mem_addr_d = fetch_pc_q + ADDR_W'(1);
                    end else begin
                        state_d  = IDLE;
                        mem_rd_d = 1'b0;
                    end
                end
            end
            DISCARD: begin
                if (mem_ack) begin
                    state_d    = FETCH;
                    mem_addr_d = fetch_pc_d;
                end
            end
            default: begin
                state_d  = IDLE;
                mem_rd_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fifo
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    fifo_q[gi] <= 8'h00;
                else if (push && wr_ptr_q == PTR_W'(gi))
                    fifo_q[gi] <= mem_data;
            end
        end
    endgenerate

    assign rd_ptr_p1  = rd_ptr_q + PTR_W'(1);
    assign mem_rd     = mem_rd_q;
    assign mem_addr   = mem_addr_q;
    assign count      = count_q;
    assign mbr_valid  = (count_q >= ONE);
    assign mbr2_valid = (count_q >= TWO);
    assign mbr_data   = fifo_q[rd_ptr_q];
    assign mbr2_data  = {fifo_q[rd_ptr_q], fifo_q[rd_ptr_p1]};
    assign pc_out     = fetch_pc_q - ADDR_W'(count_q);

endmodule
